// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcodes,
// ALU codes, the control-strobe bundle and small opcode decode helpers.
package multicycle_pkg;

   localparam int unsigned OP_W    = 4;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned ALUOP_W = 3;
   localparam int unsigned WDOG_W  = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXEC    = 3'd2,
      ST_MEMACC  = 3'd3,
      ST_WB      = 3'd4,
      ST_MULWAIT = 3'd5
   } state_e;

   // ALU-class opcodes carry their ALU operation in the low three bits
   localparam logic [OP_W-1:0] OP_ADD = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB = 4'd1;
   localparam logic [OP_W-1:0] OP_AND = 4'd2;
   localparam logic [OP_W-1:0] OP_XOR = 4'd3;
   localparam logic [OP_W-1:0] OP_SLL = 4'd4;
   localparam logic [OP_W-1:0] OP_SRL = 4'd5;
   localparam logic [OP_W-1:0] OP_COM = 4'd6;
   localparam logic [OP_W-1:0] OP_MUL = 4'd7;
   localparam logic [OP_W-1:0] OP_LW  = 4'd8;
   localparam logic [OP_W-1:0] OP_SW  = 4'd9;
   localparam logic [OP_W-1:0] OP_BEQ = 4'd10;

   localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
   localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;

   // Count value seen during the 255th consecutive wait cycle
   localparam logic [WDOG_W-1:0] WDOG_LAST = 8'd254;

   typedef struct packed {
      logic                pc_write;
      logic                ir_write;
      logic                reg_wen;
      logic                mem_req;
      logic                mem_write;
      logic                mem_to_reg;
      logic                alu_src;
      logic                reg_dst;
      logic                pc_src;
      logic                mul_start;
      logic                instr_done;
      logic [ALUOP_W-1:0]  aluop;
   } ctrl_t;

   // Defined opcodes occupy the contiguous range OP_ADD..OP_BEQ
   function automatic logic op_is_defined(input logic [OP_W-1:0] op);
      return (op <= OP_BEQ);
   endfunction

   function automatic logic [ALUOP_W-1:0] alu_code(input logic [OP_W-1:0] op);
      logic [ALUOP_W-1:0] code;
      case (op)
         OP_LW, OP_SW: code = ALU_ADD;
         OP_BEQ:       code = ALU_SUB;
         default:      code = op[ALUOP_W-1:0];
      endcase
      return code;
   endfunction

   function automatic logic op_alu_src(input logic [OP_W-1:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_LW) || (op == OP_SW);
   endfunction

   function automatic logic op_reg_dst(input logic [OP_W-1:0] op);
      return (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_wdog.sv
// wait_wdog: bounds MEMACC/MULWAIT waits; present only when MULTICYCLE_WDOG_EN
// is defined. Raises expiry on the 255th wait cycle and a sticky error flag.
`ifdef MULTICYCLE_WDOG_EN
module wait_wdog
   import multicycle_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in_wait_i,
   input  logic ack_i,
   output logic expire_c,
   output logic err_o
);

   logic [WDOG_W-1:0] cnt_q, cnt_d;
   logic              err_q, err_d;

   // Count is k-1 during the k-th wait cycle; leaving the wait state clears it
   always_comb begin
      cnt_d    = '0;
      expire_c = 1'b0;
      if (in_wait_i) begin
         cnt_d = cnt_q + WDOG_W'(1);
      end
      if (in_wait_i && !ack_i && (cnt_q == WDOG_LAST)) begin
         expire_c = 1'b1;
      end
      err_d = err_q | expire_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule
`endif

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional wait watchdog enabled by defining MULTICYCLE_WDOG_EN.
module multicycle_ctrl
   import multicycle_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   input  logic        mul_done,
   output logic        pc_write,
   output logic        ir_write,
   output logic        reg_wen,
   output logic        mem_req,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        alu_src,
   output logic        reg_dst,
   output logic        pc_src,
   output logic        mul_start,
   output logic [2:0]  aluop,
   output logic        instr_done,
   output logic        err,
   output logic [2:0]  state
);

   state_e            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   ctrl_t             ctrl_c;
   ctrl_t             out_c;
   logic              expire_c;
   logic              err_w;

`ifdef MULTICYCLE_WDOG_EN
   logic in_wait_c;
   logic ack_c;

   assign in_wait_c = (state_q == ST_MEMACC) || (state_q == ST_MULWAIT);
   assign ack_c     = ((state_q == ST_MEMACC) && mem_ready) ||
                      ((state_q == ST_MULWAIT) && mul_done);

   wait_wdog u_wait_wdog (
      .clk       (clk),
      .rst       (rst),
      .in_wait_i (in_wait_c),
      .ack_i     (ack_c),
      .expire_c  (expire_c),
      .err_o     (err_w)
   );
`else
   assign expire_c = 1'b0;
   assign err_w    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Next state and per-state strobes; strobes not set in a state stay 0
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ctrl_c  = '0;

      case (state_q)
         ST_FETCH: begin
            ctrl_c.ir_write = 1'b1;
            ctrl_c.pc_write = 1'b1;
            state_d         = ST_DECODE;
         end

         ST_DECODE: begin
            op_d = opcode;
            if (op_is_defined(opcode)) begin
               state_d = ST_EXEC;
            end else begin
               ctrl_c.instr_done = 1'b1;
               state_d           = ST_FETCH;
            end
         end

         ST_EXEC: begin
            ctrl_c.aluop   = alu_code(op_q);
            ctrl_c.alu_src = op_alu_src(op_q);
            ctrl_c.reg_dst = op_reg_dst(op_q);
            case (op_q)
               OP_MUL: begin
                  ctrl_c.mul_start = 1'b1;
                  state_d          = ST_MULWAIT;
               end
               OP_LW, OP_SW: begin
                  state_d = ST_MEMACC;
               end
               OP_BEQ: begin
                  ctrl_c.pc_src     = zero;
                  ctrl_c.pc_write   = zero;
                  ctrl_c.instr_done = 1'b1;
                  state_d           = ST_FETCH;
               end
               default: begin
                  state_d = ST_WB;
               end
            endcase
         end

         // Request stays up until the acknowledge cycle or watchdog expiry
         ST_MEMACC: begin
            ctrl_c.alu_src   = op_alu_src(op_q);
            ctrl_c.reg_dst   = op_reg_dst(op_q);
            ctrl_c.mem_write = (op_q == OP_SW);
            if (mem_ready) begin
               if (op_q == OP_SW) begin
                  ctrl_c.instr_done = 1'b1;
                  state_d           = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (expire_c) begin
               ctrl_c.instr_done = 1'b1;
               state_d           = ST_FETCH;
            end else begin
               ctrl_c.mem_req = 1'b1;
            end
         end

         ST_MULWAIT: begin
            ctrl_c.alu_src = op_alu_src(op_q);
            ctrl_c.reg_dst = op_reg_dst(op_q);
            if (mul_done) begin
               state_d = ST_WB;
            end else if (expire_c) begin
               ctrl_c.instr_done = 1'b1;
               state_d           = ST_FETCH;
            end
         end

         ST_WB: begin
            ctrl_c.alu_src    = op_alu_src(op_q);
            ctrl_c.reg_dst    = op_reg_dst(op_q);
            ctrl_c.reg_wen    = 1'b1;
            ctrl_c.mem_to_reg = (op_q == OP_LW);
            ctrl_c.instr_done = 1'b1;
            state_d           = ST_FETCH;
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Reset silences every strobe immediately, so an abandoned instruction
   // never completes or writes back
   always_comb begin
      out_c = ctrl_c;
      state = state_q;
      err   = err_w;
      if (rst) begin
         out_c = '0;
         state = ST_FETCH;
         err   = 1'b0;
      end
   end

   assign pc_write   = out_c.pc_write;
   assign ir_write   = out_c.ir_write;
   assign reg_wen    = out_c.reg_wen;
   assign mem_req    = out_c.mem_req;
   assign mem_write  = out_c.mem_write;
   assign mem_to_reg = out_c.mem_to_reg;
   assign alu_src    = out_c.alu_src;
   assign reg_dst    = out_c.reg_dst;
   assign pc_src     = out_c.pc_src;
   assign mul_start  = out_c.mul_start;
   assign instr_done = out_c.instr_done;
   assign aluop      = out_c.aluop;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL provide these ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  instruction opcode from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  data-memory acknowledge.
- mul_done  in  1  multiplier completion.
- pc_write, ir_write, reg_wen, mem_req, mem_write, mem_to_reg, alu_src, reg_dst, pc_src, mul_start  out  1 each  datapath strobes and selects.
- aluop  out  3  ALU operation select.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- err  out  1  sticky watchdog error flag.
- state  out  3  current FSM state, for debug.

Function
REQ-002 The FSM SHALL have six states with these encodings: FETCH=0, DECODE=1, EXEC=2, MEMACC=3, WB=4, MULWAIT=5.
REQ-003 In FETCH the block SHALL assert ir_write=1 and pc_write=1 for one cycle, then go to DECODE.
REQ-004 In DECODE the block SHALL latch opcode into op_q and go to EXEC.
- An opcode that is not a defined instruction SHALL go to FETCH and pulse instr_done; it executes as a NOP.
REQ-005 In EXEC, aluop SHALL be op_q[2:0] for ADD, SUB, AND, XOR, SLL, SRL, COM and MUL; the ADD code for LW and SW; and the SUB code for BEQ.
REQ-006 alu_src SHALL be 1 for SLL, SRL, LW and SW.
- reg_dst SHALL be 1 for SW and BEQ.
- Both are held from EXEC through the end of the instruction.
REQ-007 EXEC transitions:
- ALU ops go to WB.
- MUL pulses mul_start for 1 cycle and goes to MULWAIT.
- LW and SW go to MEMACC.
- BEQ sets pc_src=zero and pc_write=zero, pulses instr_done, and goes to FETCH.
REQ-008 MEMACC handshake:
- mem_req SHALL be held at 1 until the cycle in which mem_ready=1 is sampled.
- mem_write SHALL be 1 throughout MEMACC for SW.
- When mem_ready is seen, LW goes to WB; SW pulses instr_done and goes to FETCH.
- mem_ready outside MEMACC SHALL be ignored.
REQ-009 MULWAIT SHALL hold until mul_done=1 and then go to WB; mul_done outside MULWAIT SHALL be ignored.
REQ-010 WB SHALL assert reg_wen=1 for exactly one cycle, with mem_to_reg=1 only for LW, pulse instr_done, and go to FETCH.
REQ-011 Latency with zero-wait memory and multiplier:
- BEQ: 3 cycles.
- ALU ops: 4 cycles.
- SW: 4 cycles.
- LW: 5 cycles.
- MUL: 4 cycles plus the number of MULWAIT cycles.
REQ-012 Any output not explicitly asserted in a state SHALL be 0 in that state.

Reset
REQ-013 While rst=1 at a clock edge, state SHALL go to FETCH, op_q to 0, err to 0 and the watchdog count to 0.
REQ-014 During reset all outputs SHALL be 0, except state=FETCH.
REQ-015 Reset asserted mid-instruction SHALL abandon the instruction:
- mem_req and mem_write drop on the next edge.
- No reg_wen and no instr_done are issued for the abandoned instruction.
REQ-016 The first cycle after rst deasserts SHALL be FETCH, with ir_write=1.

Configuration
REQ-017 Macro MULTICYCLE_WDOG_EN. When defined, an 8-bit counter SHALL increment each cycle spent in MEMACC or MULWAIT and clear on entry to those states.
REQ-018 Watchdog expiry with MULTICYCLE_WDOG_EN:
- When the count reaches 255 with no ack, the block SHALL set err=1 (sticky until reset), drop mem_req, pulse instr_done, skip WB and go to FETCH.
- If the ack and expiry fall in the same cycle, the ack SHALL win and err SHALL stay 0.
REQ-019 Without MULTICYCLE_WDOG_EN, err SHALL be tied to 0, no counter SHALL exist, and waits SHALL be unbounded.

Structure
REQ-020 Opcode constants and state encodings SHALL live in the shared define package; the ALU and the single-cycle decoder use the same constants.
REQ-021 The watchdog SHALL be a sub-module named wait_wdog, instantiated only under MULTICYCLE_WDOG_EN; the FSM and output decode stay in multicycle_ctrl.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ADD, after reset -> states 0,1,2,4,0; reg_wen=1 only in cycle 4; aluop=ADD code in EXEC; instr_done in cycle 4.
- LW, mem_ready arriving 3 cycles after entering MEMACC -> mem_req high for exactly 3 cycles; then WB with mem_to_reg=1 and reg_wen=1; 8 cycles total.
- BEQ with zero=1, then BEQ with zero=0 -> pc_src=pc_write=1 in EXEC for the first only; both take 3 cycles; reg_wen never asserted.
- MUL with mul_done after 5 cycles -> mul_start pulses once; 5 MULWAIT cycles; then WB.
- SW, with rst=1 asserted in the second MEMACC cycle -> the next cycle shows state=0, mem_req=0, mem_write=0; no instr_done.
- With MULTICYCLE_WDOG_EN and mem_ready never asserted on LW -> err=1 after 255 MEMACC cycles; FETCH next; err stays 1 until rst.
